// File: rtl/click_decoder.sv
// Groups debounced press pulses within a gap window into single/double/triple click events
// and presents them on a valid/ready handshake. Optional macro TRIPLE_CLICK_EN enables triple clicks.
module click_decoder #(
  parameter int WINDOW_CYCLES = 25_000_000,
  parameter int CNT_W         = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pulse,
  input  logic       evt_ready,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  output logic       overrun,
  output logic       busy
);

`ifdef TRIPLE_CLICK_EN
  localparam logic [1:0] MAX_CNT = 2'd3;
`else
  localparam logic [1:0] MAX_CNT = 2'd2;
`endif
  localparam logic [CNT_W-1:0] TIMER_TOP = CNT_W'(WINDOW_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_HOLD} state_t;

  state_t           state_reg, state_next;
  logic [1:0]       count_reg, count_next;
  logic [CNT_W-1:0] timer_reg, timer_next;
  logic             evt_valid_reg, evt_valid_next;
  logic [1:0]       evt_code_reg, evt_code_next;
  logic             overrun_reg, overrun_next;
  logic             busy_reg, busy_next;

  // The group completes immediately when the incoming pulse reaches the maximum count.
  logic last_pulse;
  logic window_end;
  assign last_pulse = (count_reg + 2'd1) == MAX_CNT;
  assign window_end = timer_reg == TIMER_TOP;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      count_reg     <= '0;
      timer_reg     <= '0;
      evt_valid_reg <= 1'b0;
      evt_code_reg  <= 2'b00;
      overrun_reg   <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      timer_reg     <= timer_next;
      evt_valid_reg <= evt_valid_next;
      evt_code_reg  <= evt_code_next;
      overrun_reg   <= overrun_next;
      busy_reg      <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: if (pulse) state_next = ST_WAIT;
      ST_WAIT: begin
        if (pulse) begin
          if (last_pulse) state_next = ST_HOLD;
        end else if (window_end) begin
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: if (evt_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    count_next     = count_reg;
    timer_next     = timer_reg;
    evt_valid_next = evt_valid_reg;
    evt_code_next  = evt_code_reg;
    overrun_next   = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (pulse) begin
          count_next = 2'd1;
          timer_next = '0;
        end
      end
      ST_WAIT: begin
        // A pulse on the timeout cycle still joins the group.
        if (pulse) begin
          if (last_pulse) begin
            count_next     = MAX_CNT;
            evt_code_next  = MAX_CNT;
            evt_valid_next = 1'b1;
          end else begin
            count_next = count_reg + 2'd1;
            timer_next = '0;
          end
        end else if (window_end) begin
          evt_code_next  = count_reg;
          evt_valid_next = 1'b1;
        end else begin
          timer_next = timer_reg + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        overrun_next = pulse;
        if (evt_ready) begin
          evt_valid_next = 1'b0;
          evt_code_next  = 2'b00;
          count_next     = '0;
          timer_next     = '0;
        end
      end
      default: begin
        count_next     = '0;
        timer_next     = '0;
        evt_valid_next = 1'b0;
        evt_code_next  = 2'b00;
      end
    endcase
    busy_next = state_next != ST_IDLE;
  end

  assign evt_valid = evt_valid_reg;
  assign evt_code  = evt_code_reg;
  assign overrun   = overrun_reg;
  assign busy      = busy_reg;

endmodule
